wb_timer: RTL and testbench
===========================

# wb_timer

Pipelined Wishbone responder providing up to four 32-bit down-counting timers with per-channel interrupt outputs. It sits on a port of the I/O `mmu` (the `BASE(12)` decoder on the data bus) as an `if_wb` slave. Its `irq` vector drives the CPU `interrupts` input. It is the responder for the master-side accesses issued by the `mem` stage.

## Interface
- `CHANNELS`, 3: number of timer channels, 1..4.
- `PRESCALE`, 1: core clocks per timer tick, 1..65535.
- `clk_i` input 1: clock; all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `bus` if_wb.slave: 32-bit `adr`, `dat_m`, `dat_s`; 4-bit `sel`; 1-bit `cyc`, `stb`, `we`, `ack`, `stall`. Only `adr[5:2]` is decoded.
- `irq` output CHANNELS: per-channel interrupt, registered.

## Operation
- Register map per channel `i` is `adr[5:4]=i`, word `adr[3:2]`:
  - 0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IE, bit3 CASCADE; other bits read 0.
  - 1 RELOAD: 32-bit.
  - 2 COUNT: read returns the live count; a write loads the count.
  - 3 STATUS: bit0 EXPIRED, write-1-to-clear.
- For channel index ≥ CHANNELS: reads return 0 and writes are ignored, but are still acked.
- Writes honour `sel` per byte lane. STATUS only uses lane 0.
- Prescaler: a 16-bit counter counts 0..PRESCALE-1. `tick` is asserted in the cycle the counter wraps. With PRESCALE=1, `tick` is high every cycle.
- Channel step:
  - When EN=1 and the channel's step source fires:
    - If COUNT≠0, COUNT decrements.
    - If COUNT=0, EXPIRED is set. With AUTORELOAD=1, COUNT←RELOAD. With AUTORELOAD=0, EN←0 and COUNT stays 0.
  - The step source is `tick`, unless the cascade feature applies (see Configuration).
- `irq[i]` = registered (EXPIRED & IE).
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a step: the write wins, and no expiry is generated that cycle.
  - STATUS W1C in the same cycle as a new expiry: EXPIRED stays 1.
  - RELOAD write in the same cycle as an autoreload: the old RELOAD value is loaded.

## Timing
- `stall` is tied 0. One request is accepted per cycle when `cyc&stb`.
- `ack` is registered: high exactly one cycle after each accepted request. Back-to-back requests give back-to-back acks.
- `ack` is gated by the current `cyc`. If `cyc` drops, the pending ack is discarded, but a write that was already accepted is committed.
- `dat_s` is valid in the `ack` cycle. It holds the register value as sampled in the accept cycle, before same-cycle updates. `dat_s` is 0 for write acks.
- Write effects are visible to a read accepted the next cycle.
- Expiry → `irq` latency: EXPIRED is set at the step edge, and `irq` rises one cycle later.
- W1C → `irq` fall: one cycle after the write is committed.
- Reset (`rst_i`=0, at any time including mid-transaction): all registers 0, prescaler 0, `ack`=0, `dat_s`=0, `irq`=0. Any outstanding ack is lost.

## Configuration
- `WB_TIMER_CASCADE_EN` defined:
  - For i≥1 with CASCADE=1, channel i steps on channel i-1's expiry event instead of `tick`, in the same cycle, giving 64-bit and wider chains.
  - Channel 0 ignores CASCADE.
- `WB_TIMER_CASCADE_EN` undefined: CTRL bit3 is not stored, reads 0, and all channels step on `tick`.

## Test plan
- Reset then read all 16 words, back-to-back with no idle cycles → 16 acks on consecutive cycles, all data 0, `irq`=0.
- PRESCALE=1, ch0: RELOAD=3, COUNT=3, CTRL=0x7 (EN, AUTORELOAD, IE) → EXPIRED sets on the 4th tick after the CTRL write, `irq[0]` rises the following cycle, COUNT reads 3 again. W1C STATUS=1 → `irq[0]` low one cycle later.
- One-shot on ch1: COUNT=2, CTRL=0x5 (EN, IE) → single expiry, CTRL reads 0x4, COUNT holds 0, no further expiries over 100 cycles.
- Write COUNT=10 in the exact cycle ch0 is due to expire → no EXPIRED, COUNT reads 9 after the next tick. W1C in the expiry cycle → EXPIRED remains 1.
- Byte-lane write to RELOAD with `sel`=0b0010, data 0xAABBCCDD over 0x11223344 → reads 0x1122CC44. Drop `cyc` the cycle after a read is accepted → no ack is seen.
- `WB_TIMER_CASCADE_EN` defined: ch0 RELOAD=1 auto, ch1 COUNT=2 with CASCADE → ch1 expires on ch0's 3rd expiry. Without the macro, ch1 instead expires on the 3rd tick after it is enabled.

Source files
------------

// File: rtl/wb_timer_if.sv
// if_wb: pipelined Wishbone bundle between bus masters and I/O responders.
// 32-bit address/data, byte selects, single-cycle stall/ack signalling.
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        stall;

    modport master (
        output adr, dat_m, sel, cyc, stb, we,
        input  dat_s, ack, stall
    );

    modport slave (
        input  adr, dat_m, sel, cyc, stb, we,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: Wishbone responder with up to four 32-bit down-counting timers.
// Define WB_TIMER_CASCADE_EN to let channel i step on channel i-1 expiries.
module wb_timer #(
    parameter int CHANNELS = 3,
    parameter int PRESCALE = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    if_wb.slave                 bus,
    output logic [CHANNELS-1:0] irq
);

`ifdef WB_TIMER_CASCADE_EN
    localparam bit CASC_EN = 1'b1;
`else
    localparam bit CASC_EN = 1'b0;
`endif

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] ps_cnt;
    logic        tick;

    logic [31:0] count  [CHANNELS];
    logic [31:0] reload [CHANNELS];

    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] autoreload;
    logic [CHANNELS-1:0] ie;
    logic [CHANNELS-1:0] cascade;
    logic [CHANNELS-1:0] expired;

    logic        req;
    logic        wr;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rd_data;
    logic [1:0]  chan;
    logic [1:0]  word;

    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_reload;
    logic [CHANNELS-1:0] wr_count;
    logic [CHANNELS-1:0] wr_status;
    logic [CHANNELS-1:0] step;
    logic [CHANNELS-1:0] expire;

    assign req       = bus.cyc & bus.stb;
    assign wr        = req & bus.we;
    assign chan      = bus.adr[5:4];
    assign word      = bus.adr[3:2];
    assign bus.stall = 1'b0;
    assign bus.ack   = ack_q & bus.cyc;
    assign bus.dat_s = dat_q;
    assign tick      = (ps_cnt == PS_LAST);

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        end
        return r;
    endfunction

    // Address decode and read mux; unmapped channels read 0.
    always_comb begin
        wr_ctrl   = '0;
        wr_reload = '0;
        wr_count  = '0;
        wr_status = '0;
        rd_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan == 2'(i)) begin
                wr_ctrl[i]   = wr && (word == 2'd0);
                wr_reload[i] = wr && (word == 2'd1);
                wr_count[i]  = wr && (word == 2'd2);
                wr_status[i] = wr && (word == 2'd3);
                unique case (word)
                    2'd0: rd_data = {28'd0, cascade[i], ie[i],
                                     autoreload[i], en[i]};
                    2'd1: rd_data = reload[i];
                    2'd2: rd_data = count[i];
                    2'd3: rd_data = {31'd0, expired[i]};
                endcase
            end
        end
    end

    // Step chain: a CTRL/COUNT write in the same cycle suppresses the step.
    always_comb begin
        logic carry;
        logic src;
        carry  = 1'b0;
        src    = 1'b0;
        step   = '0;
        expire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            src = tick;
            if (CASC_EN && i > 0 && cascade[i]) src = carry;
            step[i]   = en[i] & src & ~wr_ctrl[i] & ~wr_count[i];
            expire[i] = step[i] & (count[i] == 32'd0);
            carry     = expire[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps_cnt     <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq        <= '0;
            en         <= '0;
            autoreload <= '0;
            ie         <= '0;
            cascade    <= '0;
            expired    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
            end
        end else begin
            ps_cnt <= tick ? 16'd0 : ps_cnt + 16'd1;
            ack_q  <= req;
            dat_q  <= (req && !bus.we) ? rd_data : 32'd0;
            irq    <= expired & ie;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_reload[i])
                    reload[i] <= lane_merge(reload[i], bus.dat_m, bus.sel);

                if (wr_count[i]) begin
                    count[i] <= lane_merge(count[i], bus.dat_m, bus.sel);
                end else if (step[i]) begin
                    if (count[i] != 32'd0)
                        count[i] <= count[i] - 32'd1;
                    else if (autoreload[i])
                        count[i] <= reload[i];
                end

                if (wr_ctrl[i] && bus.sel[0]) begin
                    en[i]         <= bus.dat_m[0];
                    autoreload[i] <= bus.dat_m[1];
                    ie[i]         <= bus.dat_m[2];
                    cascade[i]    <= CASC_EN && bus.dat_m[3];
                end else if (expire[i] && !autoreload[i]) begin
                    en[i] <= 1'b0;
                end

                // A fresh expiry outranks a same-cycle clear.
                if (expire[i])
                    expired[i] <= 1'b1;
                else if (wr_status[i] && bus.sel[0] && bus.dat_m[0])
                    expired[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed, table-driven checks of the wb_timer block.
// Cascade expectations follow WB_TIMER_CASCADE_EN when it is defined.
module tb_wb_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] irq;

    if_wb bus ();

    wb_timer #(.CHANNELS(3), .PRESCALE(1)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t rv[16];
    vec_t lv[6];

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] rd_v;
    logic        ak;
    int          first;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; accepted at the next edge, ack sampled 1ns later.
    task automatic xfer(input logic we, input logic [7:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output logic a);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = {24'd0, adr};
        bus.dat_m = dat;
        bus.sel   = sel;
        @(posedge clk);
        #1;
        a  = bus.ack;
        rd = bus.dat_s;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic wr(input string name, input logic [7:0] adr,
                      input logic [31:0] dat);
        logic [31:0] d;
        logic        a;
        xfer(1'b1, adr, dat, 4'hF, d, a);
        chk({name, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic rd(input string name, input logic [7:0] adr,
                      input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        xfer(1'b0, adr, 32'd0, 4'hF, d, a);
        chk({name, "_ack"}, 32'(a), 32'd1);
        chk(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        xfer(v.we, v.adr, v.dat, v.sel, rd_v, ak);
        chk({name, "_ack"}, 32'(ak), 32'd1);
        chk(name, rd_v, v.exp);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            rv[i] = '{1'b0, 8'(i * 4), 32'd0, 4'hF, 32'd0};
        lv[0] = '{1'b1, 8'h24, 32'h11223344, 4'hF, 32'd0};
        lv[1] = '{1'b1, 8'h24, 32'hAABBCCDD, 4'h2, 32'd0};
        lv[2] = '{1'b0, 8'h24, 32'd0, 4'hF, 32'h1122CC44};
        lv[3] = '{1'b1, 8'h38, 32'hFFFFFFFF, 4'hF, 32'd0};
        lv[4] = '{1'b0, 8'h38, 32'd0, 4'hF, 32'd0};
        lv[5] = '{1'b0, 8'h20, 32'd0, 4'hF, 32'd0};

        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we = 1'b0;
        bus.adr = '0;
        bus.dat_m = '0;
        bus.sel = '0;
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_dat", bus.dat_s, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All 16 words back-to-back after reset.
        for (int i = 0; i < 16; i++) begin
            run_vec("rst_rd", rv[i]);
            chk("rst_irq", 32'(irq), 32'd0);
        end

        // ch0 autoreload: RELOAD=3, COUNT=3, CTRL=EN|AR|IE.
        wr("c0_rl", 8'h04, 32'd3);
        wr("c0_cnt", 8'h08, 32'd3);
        wr("c0_ctl", 8'h00, 32'd7);
        for (int k = 0; k < 4; k++) begin
            rd("c0_dec", 8'h08, 32'(3 - k));
            chk("c0_irq_lo", 32'(irq[0]), 32'd0);
        end
        rd("c0_reld", 8'h08, 32'd3);
        chk("c0_irq_hi", 32'(irq[0]), 32'd1);
        rd("c0_st", 8'h0C, 32'd1);
        wr("c0_stop", 8'h00, 32'd4);
        wr("c0_w1c", 8'h0C, 32'd1);
        chk("c0_irq_hold", 32'(irq[0]), 32'd1);
        idle(1);
        chk("c0_irq_fall", 32'(irq[0]), 32'd0);
        rd("c0_st_clr", 8'h0C, 32'd0);

        // COUNT write collides with an expiry.
        wr("col_cnt1", 8'h08, 32'd1);
        wr("col_ctl", 8'h00, 32'd3);
        idle(1);
        wr("col_cnt10", 8'h08, 32'd10);
        rd("col_st", 8'h0C, 32'd0);
        rd("col_cnt9", 8'h08, 32'd9);
        // W1C collides with an expiry.
        wr("w1c_cnt0", 8'h08, 32'd0);
        wr("w1c_clr", 8'h0C, 32'd1);
        rd("w1c_st", 8'h0C, 32'd1);
        chk("w1c_irq", 32'(irq[0]), 32'd0);
        wr("w1c_stop", 8'h00, 32'd0);
        wr("w1c_clr2", 8'h0C, 32'd1);
        rd("w1c_st2", 8'h0C, 32'd0);

        // ch1 one-shot.
        wr("os_cnt", 8'h18, 32'd2);
        wr("os_ctl", 8'h10, 32'd5);
        idle(3);
        rd("os_st", 8'h1C, 32'd1);
        chk("os_irq", 32'(irq[1]), 32'd1);
        rd("os_ctl_rd", 8'h10, 32'd4);
        rd("os_cnt_rd", 8'h18, 32'd0);
        wr("os_w1c", 8'h1C, 32'd1);
        idle(100);
        rd("os_st2", 8'h1C, 32'd0);
        chk("os_irq2", 32'(irq[1]), 32'd0);
        rd("os_cnt2", 8'h18, 32'd0);

        // Byte lanes and unmapped channel.
        for (int i = 0; i < 6; i++) run_vec("lane", lv[i]);

        // Read accepted, cyc dropped in the ack cycle.
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = 32'h24;
        @(posedge clk);
        #1;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        #1;
        chk("drop_ack", 32'(bus.ack), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_ack2", 32'(bus.ack), 32'd0);

        // Write accepted then cyc dropped still commits.
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.adr   = 32'h24;
        bus.dat_m = 32'h55;
        bus.sel   = 4'hF;
        @(posedge clk);
        #1;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        idle(1);
        rd("drop_wr", 8'h24, 32'h55);

        // ch0 RELOAD=1 auto feeding ch1 COUNT=2.
        wr("cas_rl0", 8'h04, 32'd1);
        wr("cas_cnt0", 8'h08, 32'd1);
        wr("cas_cnt1", 8'h18, 32'd2);
        wr("cas_ctl0", 8'h00, 32'd3);
        wr("cas_ctl1", 8'h10, 32'd9);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            xfer(1'b0, 8'h1C, 32'd0, 4'hF, rd_v, ak);
            if (rd_v[0] && first == 0) first = i;
        end
`ifdef WB_TIMER_CASCADE_EN
        chk("cas_first", 32'(first), 32'd6);
        rd("cas_ctl1_rd", 8'h10, 32'd8);
`else
        chk("cas_first", 32'(first), 32'd4);
        rd("cas_ctl1_rd", 8'h10, 32'd0);
`endif
        wr("cas_stop", 8'h00, 32'd0);

        // Reset during an outstanding read.
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.adr = 32'h04;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_ack", 32'(bus.ack), 32'd0);
        chk("mrst_dat", bus.dat_s, 32'd0);
        chk("mrst_irq", 32'(irq), 32'd0);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rd("mrst_rl", 8'h04, 32'd0);
        rd("mrst_st1", 8'h1C, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
